// File: rtl/uart_boot_loader.sv
// Boot loader behind the UART receiver: parses a framed image, writes 32-bit words
// into instruction/data memory and holds the CPU in reset until the image is good.
module uart_boot_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter int         BASE_ADDR  = 0,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT    = 5000000,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code
);

  // state  | meaning
  // IDLE   | disarmed, waiting for start
  // SYNC   | armed, discarding bytes until the sync marker
  // LEN_LO | expecting word count low byte
  // LEN_HI | expecting word count high byte, range check
  // DATA   | assembling little-endian words and writing them
  // CHECK  | expecting checksum byte
  // DONE   | image loaded, CPU released
  // ERROR  | frame aborted, CPU still held
  typedef enum logic [2:0] {IDLE, SYNC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

  localparam state_t                  RESET_STATE = AUTO_START ? SYNC : IDLE;
  localparam logic [ADDR_WIDTH-1:0]   BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [63:0]             MAX_WORDS   = 64'd1 << ADDR_WIDTH;
  localparam int                      TW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]           TO_LAST     = TW'(TIMEOUT - 1);

  state_t                  state, state_next;
  logic                    mem_we_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_next;
  logic [31:0]             mem_wdata_next;
  logic                    cpu_hold_next, done_next, error_next;
  logic [1:0]              error_code_next;
  logic [7:0]              checksum, checksum_next;
  logic [1:0]              byte_idx, byte_idx_next;
  logic [15:0]             words_left, words_left_next;
  logic [TW-1:0]           timeout_cnt, timeout_next;
  logic [7:0]              len_lo, len_lo_next;
  logic [31:0]             word_buf, word_buf_next;
  logic [15:0]             new_len;
  logic                    timed, expired;

  assign busy    = (state == SYNC) || (state == LEN_LO) || (state == LEN_HI) ||
                   (state == DATA) || (state == CHECK);
  assign timed   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign expired = (timeout_cnt == TO_LAST);
  assign new_len = {rx_data, len_lo};

  always_comb begin
    state_next      = state;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    cpu_hold_next   = cpu_hold;
    done_next       = done;
    error_next      = error;
    error_code_next = error_code;
    checksum_next   = checksum;
    byte_idx_next   = byte_idx;
    words_left_next = words_left;
    timeout_next    = '0;
    len_lo_next     = len_lo;
    word_buf_next   = word_buf;

    // address advances in the cycle after each write strobe
    if (mem_we) mem_addr_next = mem_addr + ADDR_WIDTH'(1);

    if (timed && !rx_valid) begin
      timeout_next = timeout_cnt + TW'(1);
      if (expired) begin
        state_next      = ERROR;
        error_next      = 1'b1;
        error_code_next = 2'd1;
      end
    end

    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next      = SYNC;
          done_next       = 1'b0;
          error_next      = 1'b0;
          error_code_next = 2'd0;
          checksum_next   = 8'd0;
          byte_idx_next   = 2'd0;
          cpu_hold_next   = 1'b1;
          mem_addr_next   = BASE;
        end
      end
      SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_lo_next = rx_data;
          state_next  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          words_left_next = new_len;
          byte_idx_next   = 2'd0;
          if (64'(new_len) > MAX_WORDS) begin
            state_next      = ERROR;
            error_next      = 1'b1;
            error_code_next = 2'd2;
          end else if (new_len == 16'd0) begin
            state_next = CHECK;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          word_buf_next[{byte_idx, 3'b000} +: 8] = rx_data;
          checksum_next = checksum + rx_data;
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            mem_we_next     = 1'b1;
            mem_wdata_next  = {rx_data, word_buf[23:0]};
            words_left_next = words_left - 16'd1;
            if (words_left == 16'd1) state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == checksum) begin
            state_next    = DONE;
            done_next     = 1'b1;
            cpu_hold_next = 1'b0;
          end else begin
            state_next      = ERROR;
            error_next      = 1'b1;
            error_code_next = 2'd3;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RESET_STATE;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= 32'd0;
      cpu_hold    <= AUTO_START;
      done        <= 1'b0;
      error       <= 1'b0;
      error_code  <= 2'd0;
      checksum    <= 8'd0;
      byte_idx    <= 2'd0;
      words_left  <= 16'd0;
      timeout_cnt <= '0;
      len_lo      <= 8'd0;
      word_buf    <= 32'd0;
    end else begin
      state       <= state_next;
      mem_we      <= mem_we_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      cpu_hold    <= cpu_hold_next;
      done        <= done_next;
      error       <= error_next;
      error_code  <= error_code_next;
      checksum    <= checksum_next;
      byte_idx    <= byte_idx_next;
      words_left  <= words_left_next;
      timeout_cnt <= timeout_next;
      len_lo      <= len_lo_next;
      word_buf    <= word_buf_next;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: writes are scoreboarded, status
// outputs are checked inline by each scenario task.
module tb_uart_boot_loader;

  localparam int         AW      = 10;
  localparam int         TIMEOUT = 40;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold, busy, done, error;
  logic [1:0]    error_code;

  int checks   = 0;
  int failures = 0;

  logic [AW+31:0] exp_q[$];
  logic [31:0]    tx_words[$];

  uart_boot_loader #(
    .ADDR_WIDTH(AW), .BASE_ADDR(0), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  // write scoreboard
  always @(negedge clock) begin
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected: addr=%0d data=%08h, required none", mem_addr, mem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL mem_write: addr=%0d data=%08h, required addr=%0d data=%08h",
                   mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input bit bad_sum);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [31:0] w;
    sum = 8'd0;
    n   = 16'(tx_words.size());
    send_byte(SYNC);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < tx_words.size(); i++) begin
      w = tx_words[i];
      exp_q.push_back({AW'(i), w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
    send_byte(bad_sum ? sum + 8'd1 : sum);
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, cpu_hold, mem_we, mem_addr, mem_wdata, done, error, error_code} !==
        {1'b1, 1'b1, 1'b0, AW'(0), 32'd0, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_values: busy=%b hold=%b we=%b addr=%0d wdata=%08h done=%b err=%b code=%0d",
               busy, cpu_hold, mem_we, mem_addr, mem_wdata, done, error, error_code);
    end
  endtask

  task automatic test_basic();
    tx_words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(1'b0);
    checks++;
    if ({done, error, cpu_hold, error_code, busy} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL basic_status: done=%b err=%b hold=%b code=%0d busy=%b, required 1 0 0 0 0",
               done, error, cpu_hold, error_code, busy);
    end
    checks++;
    if (mem_addr !== AW'(2)) begin
      failures++;
      $display("FAIL basic_addr_after: got %0d required 2", mem_addr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_writes_missing: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_junk_prefix();
    pulse_start();
    checks++;
    if ({cpu_hold, done, mem_addr, busy} !== {1'b1, 1'b0, AW'(0), 1'b1}) begin
      failures++;
      $display("FAIL start_rearm: hold=%b done=%b addr=%0d busy=%b, required 1 0 0 1",
               cpu_hold, done, mem_addr, busy);
    end
    send_byte(8'hFF);
    send_byte(8'h00);
    tx_words = '{32'h04030201};
    send_frame(1'b0);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL junk_prefix: done=%b err=%b hold=%b pending=%0d, required 1 0 0 0",
               done, error, cpu_hold, exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    tx_words = '{32'h04030201};
    send_frame(1'b1);
    checks++;
    if ({done, error, error_code, cpu_hold} !== {1'b0, 1'b1, 2'd3, 1'b1} || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_checksum: done=%b err=%b code=%0d hold=%b pending=%0d, required 0 1 3 1 0",
               done, error, error_code, cpu_hold, exp_q.size());
    end
  endtask

  task automatic test_len_overflow();
    pulse_start();
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h04);
    checks++;
    if ({error, error_code, cpu_hold, busy} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL len_overflow: err=%b code=%0d hold=%b busy=%b, required 1 2 1 0",
               error, error_code, cpu_hold, busy);
    end
    // 0x0400 words exactly fills the address space and must be accepted
    pulse_start();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h04);
    checks++;
    if ({error, busy} !== 2'b01) begin
      failures++;
      $display("FAIL len_max_accepted: err=%b busy=%b, required 0 1", error, busy);
    end
    pulse_reset();
  endtask

  task automatic test_timeout();
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(TIMEOUT - 1);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: err=%b after %0d idle cycles, required 0", error, TIMEOUT - 1);
    end
    idle(1);
    checks++;
    if ({error, error_code, cpu_hold} !== {1'b1, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL timeout_expire: err=%b code=%0d hold=%b, required 1 1 1",
               error, error_code, cpu_hold);
    end
    // byte arriving on the expiry cycle keeps the frame alive
    pulse_start();
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    idle(TIMEOUT - 1);
    exp_q.push_back({AW'(0), 32'h04030201});
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0A);
    checks++;
    if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_rx_wins: done=%b err=%b pending=%0d, required 1 0 0",
               done, error, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if ({done, error, cpu_hold, mem_addr} !== {1'b1, 1'b0, 1'b0, AW'(0)}) begin
      failures++;
      $display("FAIL zero_len: done=%b err=%b hold=%b addr=%0d, required 1 0 0 0",
               done, error, cpu_hold, mem_addr);
    end
  endtask

  task automatic test_reset_midframe();
    pulse_start();
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_reset();
    checks++;
    if ({busy, cpu_hold, mem_we, mem_addr, mem_wdata, done, error, error_code} !==
        {1'b1, 1'b1, 1'b0, AW'(0), 32'd0, 1'b0, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL midframe_reset: busy=%b hold=%b we=%b addr=%0d wdata=%08h done=%b err=%b code=%0d",
               busy, cpu_hold, mem_we, mem_addr, mem_wdata, done, error, error_code);
    end
    tx_words = '{32'hCAFEF00D, 32'h0BADC0DE};
    send_frame(1'b0);
    checks++;
    if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reload_after_reset: done=%b err=%b pending=%0d, required 1 0 0",
               done, error, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    tx_words.delete();
    for (int i = 0; i < 5; i++) tx_words.push_back($urandom);
    send_frame(1'b0);
    checks++;
    if ({done, error, cpu_hold, mem_addr} !== {1'b1, 1'b0, 1'b0, AW'(5)} || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: done=%b err=%b hold=%b addr=%0d pending=%0d, required 1 0 0 5 0",
               done, error, cpu_hold, mem_addr, exp_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    start    = 1'b0;
    idle(3);
    test_reset();
    reset = 1'b0;
    idle(2);
    test_basic();
    test_junk_prefix();
    test_bad_checksum();
    test_len_overflow();
    test_timeout();
    test_zero_len();
    test_reset_midframe();
    test_back_to_back();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
